// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serializes one character per request into a start/data/parity/stop UART frame timed by an oversample tick
module uart_tx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sampleTick,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 txLoad,
  output logic                 txReady,
  output logic                 serialOut,
  output logic                 charSent,
  output logic [3:0]           bitIndex
);
  localparam int TW = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par;
  logic                 stop_cnt;
  logic                 bit_end;
  assign txReady = state == IDLE;
  assign bit_end = sampleTick && tick_cnt == TW'(OVERSAMPLE - 1);
  // frame sequencer: accept in IDLE, then advance one bit every OVERSAMPLE ticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      shift     <= '0;
      par       <= 1'b0;
      stop_cnt  <= 1'b0;
      bitIndex  <= '0;
      serialOut <= 1'b1;
      charSent  <= 1'b0;
    end else begin
      charSent <= 1'b0;
      if (state == IDLE) begin
        if (txLoad) begin
          shift     <= txData;
          par       <= (^txData) ^ (PARITY_ODD != 0);
          tick_cnt  <= '0;
          stop_cnt  <= 1'b0;
          bitIndex  <= '0;
          serialOut <= 1'b0;
          state     <= START;
        end
      end else if (sampleTick) begin
        tick_cnt <= tick_cnt + 1'b1;
        if (bit_end) begin
          case (state)
            START: begin
              state     <= DATA;
              serialOut <= shift[0];
            end
            DATA: begin
              if (bitIndex == 4'(DATA_BITS - 1)) begin
                bitIndex  <= '0;
                state     <= (PARITY_EN != 0) ? PARITY : STOP;
                serialOut <= (PARITY_EN != 0) ? par : 1'b1;
              end else begin
                shift     <= {1'b0, shift[DATA_BITS-1:1]};
                bitIndex  <= bitIndex + 1'b1;
                serialOut <= shift[1];
              end
            end
            PARITY: begin
              state     <= STOP;
              serialOut <= 1'b1;
            end
            STOP: begin
              if (stop_cnt == 1'(STOP_BITS - 1)) begin
                state    <= IDLE;
                charSent <= 1'b1;
              end else begin
                stop_cnt <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: randomized scoreboard bench over four frame formats (8N1, 8E1, 8O2, 8N2)
module tb_uart_tx_framer;
  logic clk = 1'b0;
  int checks = 0;
  int passed = 0;
  localparam logic [3:0] PE_V = 4'b0110;
  localparam logic [3:0] PO_V = 4'b0100;
  localparam logic [3:0] S2_V = 4'b1100;
  always #5 clk = ~clk;
  task automatic chk(input bit ok, input string nm, input int g, input longint got, input longint exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", g, nm, got, exp, $time);
  endtask
  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int PE = PE_V[g] ? 1 : 0;
    localparam int PO = PO_V[g] ? 1 : 0;
    localparam int SB = S2_V[g] ? 2 : 1;
    localparam int NB = 9 + PE + SB;
    localparam int FL = NB * 16;
    logic rst = 1'b1;
    logic sampleTick = 1'b0;
    logic txLoad = 1'b0;
    logic [7:0] txData = 8'h00;
    logic txReady, serialOut, charSent;
    logic [3:0] bitIndex;
    bit fin = 1'b0;
    bit m_idle = 1'b1;
    bit m_sent = 1'b0;
    bit active = 1'b0;
    int m_rem = 0;
    int mode = 0;
    int ph = 0;
    int bad;
    logic [15:0] w;
    logic [15:0] exp_q[$];
    bit lvl[$];
    logic [3:0] bq[$];
    uart_tx_framer #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(SB), .PARITY_EN(PE), .PARITY_ODD(PO)) dut (
      .clk(clk), .rst(rst), .sampleTick(sampleTick), .txData(txData), .txLoad(txLoad),
      .txReady(txReady), .serialOut(serialOut), .charSent(charSent), .bitIndex(bitIndex)
    );
    function automatic logic [15:0] frame_word(input logic [7:0] d);
      logic [15:0] fw = '1;
      fw[0] = 1'b0;
      for (int i = 0; i < 8; i++) fw[i+1] = d[i];
      if (PE == 1) fw[9] = ($countones(d) % 2 == 1) ^ (PO == 1);
      return fw;
    endfunction
    function automatic logic [3:0] exp_bidx(input int i);
      int b = i / 16;
      return (b >= 1 && b <= 8) ? 4'(b - 1) : 4'd0;
    endfunction
    always @(posedge clk) begin
      #1;
      ph = ph + 1;
      sampleTick = (mode == 0) ? 1'b1 : (mode == 1) ? (ph % 3 == 0) : ($urandom_range(1, 0) == 1);
    end
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        m_idle <= 1'b1;
        m_sent <= 1'b0;
        m_rem  <= 0;
        exp_q.delete();
      end else begin
        m_sent <= 1'b0;
        if (m_idle) begin
          if (txLoad) begin
            m_idle <= 1'b0;
            m_rem  <= FL;
            exp_q.push_back(frame_word(txData));
          end
        end else if (sampleTick) begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_idle <= 1'b1;
            m_sent <= 1'b1;
          end
        end
      end
    end
    always @(negedge clk) begin
      if (!rst) begin
        active = 1'b0;
        lvl.delete();
        bq.delete();
      end else begin
        chk(txReady == m_idle, "txReady", g, txReady, m_idle);
        chk(charSent == m_sent, "charSent", g, charSent, m_sent);
        if (m_idle) chk(serialOut == 1'b1, "idle_line", g, serialOut, 1);
        if (charSent) begin
          if (exp_q.size() == 0) chk(1'b0, "frame_unexpected", g, lvl.size(), 0);
          else begin
            w = exp_q.pop_front();
            bad = -1;
            for (int i = 0; i < lvl.size() && i < FL; i++)
              if (bad < 0 && (lvl[i] != w[i/16] || bq[i] != exp_bidx(i))) bad = i;
            chk(lvl.size() == FL, "frame_len", g, lvl.size(), FL);
            chk(bad == -1, "frame_bits_first_bad_tick", g, bad, -1);
          end
          active = 1'b0;
          lvl.delete();
          bq.delete();
        end else begin
          if (!active && serialOut == 1'b0) active = 1'b1;
          if (active && sampleTick) begin
            lvl.push_back(serialOut);
            bq.push_back(bitIndex);
          end
        end
      end
    end
    task automatic send(input logic [7:0] d, input bit chk_lat);
      int n = 0;
      @(posedge clk); #1;
      txData = d;
      txLoad = 1'b1;
      @(posedge clk); #1;
      txLoad = 1'b0;
      txData = 8'($urandom);
      forever begin
        @(negedge clk);
        if (charSent || n > FL * 8) break;
        @(posedge clk);
        n++;
      end
      chk(charSent == 1'b1, "sent_timeout", g, charSent, 1);
      if (chk_lat) chk(n == FL, "latency", g, n, FL);
    endtask
    initial begin
      int n;
      rst = 1'b0;
      #3;
      chk(serialOut == 1'b1, "rst_line", g, serialOut, 1);
      chk(txReady == 1'b1, "rst_ready", g, txReady, 1);
      chk(charSent == 1'b0, "rst_sent", g, charSent, 0);
      chk(bitIndex == 4'd0, "rst_bidx", g, bitIndex, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (50) @(posedge clk);
      send(8'hA5, 1'b1);
      for (int i = 0; i < 6; i++) begin
        mode = $urandom_range(1, 0) == 1 ? 2 : 0;
        send(8'($urandom), mode == 0);
      end
      mode = 1;
      send(8'h00, 1'b0);
      mode = 0;
      @(posedge clk); #1;
      txData = 8'h55;
      txLoad = 1'b1;
      repeat (60) @(posedge clk);
      #1 txData = 8'h0F;
      for (n = 0; n < 4 * FL; n++) begin
        @(negedge clk);
        if (charSent) break;
      end
      chk(charSent == 1'b1, "b2b_first_sent", g, charSent, 1);
      @(negedge clk);
      chk(serialOut == 1'b0, "b2b_start", g, serialOut, 0);
      chk(txReady == 1'b0, "b2b_busy", g, txReady, 0);
      @(posedge clk); #1 txLoad = 1'b0;
      for (n = 0; n < 4 * FL; n++) begin
        @(negedge clk);
        if (charSent) break;
      end
      chk(charSent == 1'b1, "b2b_second_sent", g, charSent, 1);
      @(posedge clk); #1;
      txData = 8'($urandom) & 8'hF7;
      txLoad = 1'b1;
      @(posedge clk); #1 txLoad = 1'b0;
      for (n = 0; n < 200; n++) begin
        @(negedge clk);
        if (bitIndex == 4'd3) break;
      end
      chk(bitIndex == 4'd3, "reach_bit3", g, bitIndex, 3);
      #2 rst = 1'b0;
      #1;
      chk(serialOut == 1'b1, "abort_line", g, serialOut, 1);
      chk(txReady == 1'b1, "abort_ready", g, txReady, 1);
      chk(bitIndex == 4'd0, "abort_bidx", g, bitIndex, 0);
      chk(charSent == 1'b0, "abort_sent", g, charSent, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (40) @(posedge clk);
      send(8'h3C, 1'b1);
      repeat (5) @(posedge clk);
      fin = 1'b1;
    end
  end
  initial begin
    bit all;
    all = 1'b0;
    for (int c = 0; c < 40000 && !all; c++) begin
      @(posedge clk);
      all = cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin;
    end
    chk(all, "bench_timeout", -1, all, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
